// File: rtl/seq_ctrl.sv
// Instruction sequencer: steps each decoded instruction through FETCH, DECODE,
// EXEC, optional MEM and WB, maintaining the PC, the retired count and the strobes.
module seq_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] start_address_i,
    input  logic [1:0]  format_i,
    input  logic [3:0]  opcode_i,
    input  logic        imm_flag_i,
    input  logic        branch_taken_i,
    input  logic [15:0] target_i,
    input  logic        mem_ready_i,
    output logic [15:0] pc_o,
    output logic        ir_load_o,
    output logic        alu_src_imm_o,
    output logic        reg_we_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        busy_o,
    output logic        halt_o,
    output logic        fault_o,
    output logic [15:0] retired_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [1:0] FMT_ALU_REG = 2'b00;
    localparam logic [1:0] FMT_ALU_IMM = 2'b01;
    localparam logic [1:0] FMT_MEM     = 2'b10;
    localparam logic [1:0] FMT_CTRL    = 2'b11;
    localparam logic [7:0] TIMEOUT     = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] retired_q, retired_d;
    logic [1:0]  fmt_q, fmt_d;
    logic [3:0]  op_q, op_d;
    logic        branch_q, branch_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        fault_q, fault_d;
    logic        ir_load_q, ir_load_d;
    logic        alu_imm_q, alu_imm_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        busy_q, busy_d;
    logic        halt_q, halt_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        fmt_d      = fmt_q;
        op_d       = op_q;
        branch_d   = branch_q;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;

        if (start_i) begin
            state_d = FETCH;
            pc_d    = start_address_i;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                FETCH: state_d = DECODE;
                DECODE: begin
                    fmt_d   = format_i;
                    op_d    = opcode_i;
                    state_d = (format_i == FMT_CTRL && opcode_i == 4'hF) ? HALT : EXEC;
                end
                EXEC: begin
                    branch_d   = (fmt_q == FMT_CTRL) &&
                                 ((op_q == 4'h0 && branch_taken_i) || op_q == 4'h1);
                    wait_cnt_d = 8'd0;
                    state_d    = (fmt_q == FMT_MEM) ? MEM : WB;
                end
                MEM: begin
                    if (mem_ready_i) begin
                        state_d = WB;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        if (wait_cnt_d == TIMEOUT) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                        end
                    end
                end
                WB: begin
                    pc_d      = branch_q ? target_i : pc_q + 16'd1;
                    retired_d = retired_q + 16'd1;
                    state_d   = FETCH;
                end
                default: state_d = state_q;
            endcase
        end

        // Strobes decode the state being entered so they appear registered with it.
        ir_load_d = (state_d == FETCH);
        busy_d    = (state_d == FETCH) || (state_d == DECODE) || (state_d == EXEC) ||
                    (state_d == MEM) || (state_d == WB);
        halt_d    = (state_d == HALT);
        alu_imm_d = (state_d == EXEC) && (imm_flag_i || fmt_d == FMT_ALU_IMM);
        mem_req_d = (state_d == MEM);
        mem_we_d  = (state_d == MEM) && op_d[0];
        reg_we_d  = (state_d == WB) &&
                    (fmt_d == FMT_ALU_REG || fmt_d == FMT_ALU_IMM ||
                     (fmt_d == FMT_MEM && !op_d[0]));
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= 16'd0;
            retired_q  <= 16'd0;
            fmt_q      <= 2'b00;
            op_q       <= 4'd0;
            branch_q   <= 1'b0;
            wait_cnt_q <= 8'd0;
            fault_q    <= 1'b0;
            ir_load_q  <= 1'b0;
            alu_imm_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            fmt_q      <= fmt_d;
            op_q       <= op_d;
            branch_q   <= branch_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            ir_load_q  <= ir_load_d;
            alu_imm_q  <= alu_imm_d;
            reg_we_q   <= reg_we_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            halt_q     <= halt_d;
        end
    end

    assign pc_o          = pc_q;
    assign retired_o     = retired_q;
    assign ir_load_o     = ir_load_q;
    assign alu_src_imm_o = alu_imm_q;
    assign reg_we_o      = reg_we_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign busy_o        = busy_q;
    assign halt_o        = halt_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: each instruction's expected outcome is queued
// when it is driven and compared once the sequencer fetches again or halts.
module tb_seq_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_i, start_i, imm_flag_i, branch_taken_i, mem_ready_i;
    logic [15:0] start_address_i, target_i;
    logic [1:0]  format_i;
    logic [3:0]  opcode_i;
    logic [15:0] pc_o, retired_o;
    logic        ir_load_o, alu_src_imm_o, reg_we_o, mem_req_o, mem_we_o;
    logic        busy_o, halt_o, fault_o;

    seq_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .start_address_i(start_address_i),
        .format_i(format_i), .opcode_i(opcode_i), .imm_flag_i(imm_flag_i),
        .branch_taken_i(branch_taken_i), .target_i(target_i), .mem_ready_i(mem_ready_i),
        .pc_o(pc_o), .ir_load_o(ir_load_o), .alu_src_imm_o(alu_src_imm_o),
        .reg_we_o(reg_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .busy_o(busy_o), .halt_o(halt_o), .fault_o(fault_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ret;
        int          we;
        int          memreq;
        int          memwe;
        int          lat;
        logic        halt;
        logic        fault;
        logic        imm;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_pc  = 16'd0;
    logic [15:0] m_ret = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; leaves the DUT in FETCH at the next falling edge.
    task automatic do_start(input logic [15:0] addr);
        start_i = 1'b1;
        start_address_i = addr;
        @(negedge clk);
        start_i = 1'b0;
        m_pc = addr;
        check_eq("start_ir_load", ir_load_o, 1'b1);
        check_eq("start_pc", pc_o, addr);
        check_eq("start_halt", halt_o, 1'b0);
        check_eq("start_fault", fault_o, 1'b0);
        check_eq("start_busy", busy_o, 1'b1);
        $display("start addr=0x%04h pc=0x%04h ret=%0d", addr, pc_o, retired_o);
    endtask

    // Called at the falling edge of a FETCH cycle.
    task automatic run_instr(input string name, input logic [1:0] fmt, input logic [3:0] op,
                             input logic imm, input logic taken, input logic [15:0] tgt,
                             input int delay);
        exp_t e;
        exp_t g;
        logic is_halt, is_mem, tmo, br;
        int   cyc;
        bit   done;

        is_halt = (fmt == 2'b11) && (op == 4'hF);
        is_mem  = (fmt == 2'b10);
        tmo     = is_mem && (delay >= TO);
        e.imm   = !is_halt && (imm || fmt == 2'b01);
        e.fault = tmo;
        e.halt  = is_halt || tmo;
        if (is_halt) begin
            e.we = 0; e.memreq = 0; e.memwe = 0; e.lat = 2;
        end else if (tmo) begin
            e.we = 0; e.memreq = TO; e.memwe = op[0] ? TO : 0; e.lat = 3 + TO;
        end else begin
            br    = (fmt == 2'b11) && ((op == 4'h0 && taken) || op == 4'h1);
            m_pc  = br ? tgt : m_pc + 16'd1;
            m_ret = m_ret + 16'd1;
            e.we     = (fmt != 2'b11 && !(fmt == 2'b10 && op[0])) ? 1 : 0;
            e.memreq = is_mem ? delay + 1 : 0;
            e.memwe  = (is_mem && op[0]) ? delay + 1 : 0;
            e.lat    = is_mem ? 5 + delay : 4;
        end
        e.pc  = m_pc;
        e.ret = m_ret;
        sb_q.push_back(e);

        format_i = fmt; opcode_i = op; imm_flag_i = imm;
        branch_taken_i = taken; target_i = tgt; mem_ready_i = 1'b0;
        g.we = 0; g.memreq = 0; g.memwe = 0; g.imm = 1'b0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (reg_we_o) g.we++;
            if (alu_src_imm_o) g.imm = 1'b1;
            if (mem_req_o) begin
                g.memreq++;
                if (mem_we_o) g.memwe++;
                mem_ready_i = (g.memreq > delay);
            end else begin
                mem_ready_i = 1'b0;
            end
            if (ir_load_o || halt_o) done = 1'b1;
        end
        check_eq({name, "_completes"}, done, 1'b1);
        e = sb_q.pop_front();
        check_eq({name, "_latency"}, cyc, e.lat);
        check_eq({name, "_pc"}, pc_o, e.pc);
        check_eq({name, "_retired"}, retired_o, e.ret);
        check_eq({name, "_reg_we"}, g.we, e.we);
        check_eq({name, "_mem_req"}, g.memreq, e.memreq);
        check_eq({name, "_mem_we"}, g.memwe, e.memwe);
        check_eq({name, "_alu_imm"}, g.imm, e.imm);
        check_eq({name, "_halt"}, halt_o, e.halt);
        check_eq({name, "_fault"}, fault_o, e.fault);
        $display("instr %s fmt=%0d op=0x%0h cycles=%0d pc=0x%04h ret=%0d we=%0d memreq=%0d halt=%0b fault=%0b",
                 name, fmt, op, cyc, pc_o, retired_o, g.we, g.memreq, halt_o, fault_o);
    endtask

    initial begin
        int w;
        rst_i = 1'b1; start_i = 1'b0; start_address_i = 16'd0; format_i = 2'b00;
        opcode_i = 4'd0; imm_flag_i = 1'b0; branch_taken_i = 1'b0; target_i = 16'd0;
        mem_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check_eq("rst_pc", pc_o, 16'd0);
        check_eq("rst_retired", retired_o, 16'd0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_ir_load", ir_load_o, 1'b0);
        check_eq("rst_halt", halt_o, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("idle_hold_busy", busy_o, 1'b0);
        check_eq("idle_hold_ir_load", ir_load_o, 1'b0);
        $display("reset pc=0x%04h ret=%0d busy=%0b", pc_o, retired_o, busy_o);

        do_start(16'h0005);
        for (int i = 0; i < 4; i++) run_instr("alu_reg", 2'b00, 4'h3, 1'b0, 1'b0, 16'h0, 0);
        check_eq("four_alu_pc", pc_o, 16'h0009);
        check_eq("four_alu_retired", retired_o, 16'd4);
        run_instr("alu_imm", 2'b01, 4'h2, 1'b0, 1'b0, 16'h0, 0);
        run_instr("alu_reg_immflag", 2'b00, 4'h1, 1'b1, 1'b0, 16'h0, 0);
        run_instr("br_taken", 2'b11, 4'h0, 1'b0, 1'b1, 16'h000A, 0);
        run_instr("br_not_taken", 2'b11, 4'h0, 1'b0, 1'b0, 16'h0100, 0);
        run_instr("jump", 2'b11, 4'h1, 1'b0, 1'b0, 16'h1234, 0);
        run_instr("nop", 2'b11, 4'h5, 1'b0, 1'b1, 16'h0200, 0);
        run_instr("load_wait3", 2'b10, 4'h0, 1'b0, 1'b0, 16'h0, 3);
        run_instr("store", 2'b10, 4'h1, 1'b0, 1'b0, 16'h0, 0);
        run_instr("load_timeout", 2'b10, 4'h0, 1'b0, 1'b0, 16'h0, 255);
        repeat (2) @(negedge clk);
        check_eq("timeout_busy", busy_o, 1'b0);
        do_start(16'h0000);
        run_instr("after_fault", 2'b00, 4'h0, 1'b0, 1'b0, 16'h0, 0);

        run_instr("halt_op", 2'b11, 4'hF, 1'b0, 1'b0, 16'h0, 0);
        repeat (3) @(negedge clk);
        check_eq("halt_pc_frozen", pc_o, m_pc);
        check_eq("halt_busy", busy_o, 1'b0);
        check_eq("halt_stays", halt_o, 1'b1);

        // Restart while an ALU instruction sits in EXEC.
        do_start(16'h0020);
        format_i = 2'b00; opcode_i = 4'h0; imm_flag_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_exec_state", alu_src_imm_o | busy_o, 1'b1);
        do_start(16'h0040);
        check_eq("mid_exec_reg_we", reg_we_o, 1'b0);
        check_eq("mid_exec_retired", retired_o, m_ret);
        run_instr("post_restart", 2'b00, 4'h0, 1'b0, 1'b0, 16'h0, 0);

        do_start(16'hFFFF);
        run_instr("pc_wrap", 2'b01, 4'h0, 1'b0, 1'b0, 16'h0, 0);
        check_eq("pc_wrap_zero", pc_o, 16'h0000);

        // Asynchronous reset while a load is waiting in MEM.
        do_start(16'h0100);
        format_i = 2'b10; opcode_i = 4'h0; mem_ready_i = 1'b0;
        w = 0;
        while (!mem_req_o && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("reach_mem", mem_req_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check_eq("rst_mem_req", mem_req_o, 1'b0);
        check_eq("rst_mem_busy", busy_o, 1'b0);
        check_eq("rst_mem_pc", pc_o, 16'd0);
        check_eq("rst_mem_retired", retired_o, 16'd0);
        m_pc = 16'd0;
        m_ret = 16'd0;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_mem_idle", busy_o | ir_load_o, 1'b0);
        $display("reset during MEM: mem_req=%0b busy=%0b pc=0x%04h", mem_req_o, busy_o, pc_o);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, maximum MEM wait cycles before fault (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  load start_address_i into PC and begin execution.
REQ-005 start_address_i  in  16  initial PC.
REQ-006 format_i  in  2  decoded instruction format.
REQ-007 opcode_i  in  4  decoded opcode.
REQ-008 imm_flag_i  in  1  immediate operand flag.
REQ-009 branch_taken_i  in  1  ALU branch condition, sampled in EXEC.
REQ-010 target_i  in  16  branch/jump target.
REQ-011 mem_ready_i  in  1  data memory completion for the current request.
REQ-012 pc_o  out  16  current program counter.
REQ-013 ir_load_o  out  1  capture instruction at pc_o.
REQ-014 alu_src_imm_o  out  1  ALU operand 2 from immediate.
REQ-015 reg_we_o  out  1  register file write strobe.
REQ-016 mem_req_o / mem_we_o  out  1 each  memory request / write qualifier.
REQ-017 busy_o / halt_o / fault_o  out  1 each  executing / halted / memory timeout.
REQ-018 retired_o  out  16  retired instruction count.

Function
REQ-019 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one-hot or binary encoding is permitted.
REQ-020 Classes: format 00 = ALU reg; 01 = ALU imm; 10 = memory (opcode[0] 0 = load, 1 = store); 11 = control (opcode 0 = conditional branch, 1 = jump, F = halt, others = NOP).
REQ-021 In any state, start_i high on an edge loads pc_o <= start_address_i, clears fault_o and halt_o, and enters FETCH; no reg_we_o or mem_req_o is asserted that cycle; start_i has priority over all other transitions.
REQ-022 FETCH: ir_load_o = 1 for exactly one cycle, then DECODE.
REQ-023 DECODE: one cycle, then EXEC; halt opcode goes to HALT instead.
REQ-024 EXEC: alu_src_imm_o = imm_flag_i (forced 1 for format 01); the block latches the branch decision (opcode 0 AND branch_taken_i, or opcode 1); next state is MEM for format 10, else WB.
REQ-025 MEM: mem_req_o = 1 and mem_we_o = store, held until mem_ready_i = 1 (the cycle ready is seen completes the access) -> WB.
REQ-026 MEM wait counter counts cycles with mem_ready_i = 0; when it reaches MEM_TIMEOUT, the block sets fault_o = 1, drops mem_req_o, and enters HALT.
REQ-027 WB: reg_we_o = 1 for exactly one cycle for formats 00, 01 and load; otherwise 0.
REQ-028 WB: pc_o <= latched branch ? target_i : pc_o + 1, modulo 2^16 (0xFFFF + 1 = 0x0000); retired_o increments (wraps at 0xFFFF); then FETCH.
REQ-029 Instruction latency, ignoring memory wait: 4 cycles non-memory (FETCH, DECODE, EXEC, WB), 5 cycles memory.
REQ-030 HALT: halt_o = 1, busy_o = 0, pc_o and retired_o hold; exit only via start_i or rst_i.
REQ-031 busy_o = 1 in FETCH, DECODE, EXEC, MEM and WB; 0 in IDLE and HALT.
REQ-032 All strobe outputs are registered decodes of the current state; none depend combinationally on start_i.

Reset
REQ-033 rst_i high forces IDLE immediately, including mid-instruction or mid-MEM, and sets pc_o = 0, retired_o = 0, and all flags and strobes = 0.
REQ-034 After rst_i falls, the block stays in IDLE until start_i is seen.

Verification
REQ-035 Reset, then start_i with start_address_i = 0x0005, then four ALU instructions (format 00) -> ir_load_o at cycles 1, 5, 9, 13; pc_o = 0x0009; retired_o = 4; reg_we_o pulses 4 times.
REQ-036 Conditional branch with target_i = 0x000A: branch_taken_i = 1 -> pc_o = 0x000A after WB; branch_taken_i = 0 -> pc_o = previous + 1; reg_we_o never asserted.
REQ-037 Load with mem_ready_i delayed 3 cycles -> mem_req_o high 4 cycles, then reg_we_o one pulse; a store -> mem_we_o = 1, reg_we_o = 0.
REQ-038 Memory access with mem_ready_i held at 0 and MEM_TIMEOUT = 15 -> fault_o = 1 and halt_o = 1 after 15 wait cycles; a following start_i with 0x0000 clears both and fetches from pc_o = 0x0000.
REQ-039 Halt opcode -> halt_o = 1, pc_o frozen; start_i asserted mid-EXEC -> immediate FETCH at start_address_i with no write strobe.
REQ-040 PC at 0xFFFF executing a non-branch -> pc_o = 0x0000; rst_i asserted during MEM -> mem_req_o = 0 in the same cycle and state = IDLE.
